// File: rtl/semaphore_data_encoder.sv
// Write side of the hardware semaphore block. Per-core TAKE/GIVE requests are
// serialised round-robin, and the ownership state is published as per-core status nibbles.
module semaphore_data_encoder #(
  parameter int NumberOfSemaphores = 4,
  parameter int NumberOfCores      = 2
) (
  input  logic                                           CLK,
  input  logic                                           RST,
  input  logic [NumberOfCores-1:0]                       SEMAPHOREDATAENCODER_Req_fromCPU,
  input  logic [8*NumberOfCores-1:0]                     SEMAPHOREDATAENCODER_Addr_fromCPU,
  input  logic [4*NumberOfCores-1:0]                     SEMAPHOREDATAENCODER_Cmd_fromCPU,
  output logic [NumberOfCores-1:0]                       SEMAPHOREDATAENCODER_Ack_toCPU,
  output logic [4*NumberOfSemaphores*NumberOfCores-1:0]  SEMAPHOREDATAENCODER_Data_toSemaphore
);

  localparam int NS = NumberOfSemaphores;
  localparam int NC = NumberOfCores;
  localparam int OW = $clog2(NC);
  localparam int SW = $clog2(NS);
  localparam int DW = $clog2(NS * NC);

  localparam logic [3:0] CMD_TAKE = 4'h1;
  localparam logic [3:0] CMD_GIVE = 4'h2;

  logic [NS-1:0]          held;
  logic [NS-1:0][OW-1:0]  owner;
  logic [NS*NC-1:0]       denied;
  logic [OW-1:0]          ptr;

  logic [7:0]             addr_arr [NC];
  logic [3:0]             cmd_arr  [NC];
  logic [NC-1:0]          eligible;
  logic                   grant_valid;
  logic [OW-1:0]          grant_idx;
  logic [OW-1:0]          cand;
  logic [7:0]             sel_addr;
  logic [3:0]             sel_cmd;
  logic                   addr_ok;
  logic [SW-1:0]          sel_sem;
  logic [DW-1:0]          den_idx;

  always_comb begin
    for (int c = 0; c < NC; c++) begin
      addr_arr[c] = SEMAPHOREDATAENCODER_Addr_fromCPU[8*c +: 8];
      cmd_arr[c]  = SEMAPHOREDATAENCODER_Cmd_fromCPU[4*c +: 4];
    end
  end

  // A core whose ack is high this cycle is masked so the same request is not granted twice.
  always_comb begin
    eligible    = SEMAPHOREDATAENCODER_Req_fromCPU & ~SEMAPHOREDATAENCODER_Ack_toCPU;
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int i = 0; i < NC; i++) begin
      cand = OW'((int'(ptr) + i) % NC);
      if (!grant_valid && eligible[cand]) begin
        grant_valid = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  always_comb begin
    sel_addr = addr_arr[grant_idx];
    sel_cmd  = cmd_arr[grant_idx];
    addr_ok  = (int'(sel_addr) < NS);
    sel_sem  = SW'(sel_addr);
    den_idx  = DW'(int'(sel_sem) * NC + int'(grant_idx));
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      held                           <= '0;
      owner                          <= '0;
      denied                         <= '0;
      ptr                            <= '0;
      SEMAPHOREDATAENCODER_Ack_toCPU <= '0;
    end else begin
      SEMAPHOREDATAENCODER_Ack_toCPU <= '0;
      if (grant_valid) begin
        SEMAPHOREDATAENCODER_Ack_toCPU[grant_idx] <= 1'b1;
        ptr <= (grant_idx == OW'(NC - 1)) ? '0 : grant_idx + 1'b1;
        // Out-of-range addresses and NOP commands are acked without touching any state.
        if (addr_ok) begin
          case (sel_cmd)
            CMD_TAKE: begin
              if (!held[sel_sem]) begin
                held[sel_sem]   <= 1'b1;
                owner[sel_sem]  <= grant_idx;
                denied[den_idx] <= 1'b0;
              end else if (owner[sel_sem] == grant_idx) begin
                denied[den_idx] <= 1'b0;
              end else begin
                denied[den_idx] <= 1'b1;
              end
            end
            CMD_GIVE: begin
              if (held[sel_sem] && owner[sel_sem] == grant_idx) begin
                held[sel_sem]   <= 1'b0;
                denied[den_idx] <= 1'b0;
              end else begin
                denied[den_idx] <= 1'b1;
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

  // Status nibbles depend only on registered state, so there is no input-to-output path.
  always_comb begin
    for (int s = 0; s < NS; s++) begin
      for (int c = 0; c < NC; c++) begin
        SEMAPHOREDATAENCODER_Data_toSemaphore[4*(s*NC+c) +: 4] = {
          1'b0,
          denied[s*NC+c],
          held[s] && (owner[s] != OW'(c)),
          held[s] && (owner[s] == OW'(c))
        };
      end
    end
  end

endmodule

// File: tb/tb_semaphore_data_encoder.sv
// Directed bench for semaphore_data_encoder: handshake timing, TAKE/GIVE outcomes,
// round-robin alternation and asynchronous reset, all against hand-computed status words.
module tb_semaphore_data_encoder;

  localparam int NS = 4;
  localparam int NC = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [NC-1:0] req;
  logic [15:0]   addr;
  logic [7:0]    cmd;
  logic [NC-1:0] ack;
  logic [31:0]   data;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q[$];

  semaphore_data_encoder #(
    .NumberOfSemaphores(NS),
    .NumberOfCores(NC)
  ) dut (
    .CLK(clk),
    .RST(rst),
    .SEMAPHOREDATAENCODER_Req_fromCPU(req),
    .SEMAPHOREDATAENCODER_Addr_fromCPU(addr),
    .SEMAPHOREDATAENCODER_Cmd_fromCPU(cmd),
    .SEMAPHOREDATAENCODER_Ack_toCPU(ack),
    .SEMAPHOREDATAENCODER_Data_toSemaphore(data)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic apply_reset();
    rst  = 1'b1;
    req  = '0;
    addr = '0;
    cmd  = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Full handshake for one core: raise req, wait (bounded) for ack, drop req, confirm single-cycle ack.
  task automatic do_req(input int core, input logic [7:0] a, input logic [3:0] c);
    bit seen;
    seen = 1'b0;
    @(negedge clk);
    addr[8*core +: 8] = a;
    cmd[4*core +: 4]  = c;
    req[core]         = 1'b1;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (ack[core]) seen = 1'b1;
    end
    req[core] = 1'b0;
    check("ack_seen", 32'(seen), 32'd1);
    @(negedge clk);
    check("ack_one_cycle", 32'(ack[core]), 32'd0);
  endtask

  initial begin
    apply_reset();
    repeat (5) @(negedge clk);
    check("idle_ack", 32'(ack), 32'd0);
    check("idle_data", data, 32'h0000_0000);

    do_req(0, 8'd2, 4'h1);
    check("c0_take_s2", data, 32'h0021_0000);
    do_req(1, 8'd2, 4'h1);
    check("c1_take_s2_denied", data, 32'h0061_0000);
    do_req(0, 8'd2, 4'h2);
    check("c0_give_s2", data, 32'h0040_0000);

    // simultaneous TAKE of sem0
    apply_reset();
    check("reset_data", data, 32'h0000_0000);
    @(negedge clk);
    addr = 16'h0000;
    cmd  = 8'h11;
    req  = 2'b11;
    @(negedge clk);
    check("sim_first_ack", 32'(ack), 32'd1);
    req[0] = 1'b0;
    @(negedge clk);
    check("sim_second_ack", 32'(ack), 32'd2);
    req[1] = 1'b0;
    @(negedge clk);
    check("sim_ack_clear", 32'(ack), 32'd0);
    check("sim_data", data, 32'h0000_0061);

    // continuous NOP requests alternate grants
    for (int i = 0; i < 8; i++) exp_q.push_back((i % 2 == 0) ? 32'd1 : 32'd2);
    @(negedge clk);
    cmd = 8'h00;
    req = 2'b11;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("nop_grant", 32'(ack), exp_q.pop_front());
    end
    req = '0;
    check("nop_data", data, 32'h0000_0061);
    do_req(0, 8'd200, 4'h1);
    check("bad_addr_data", data, 32'h0000_0061);

    // reset in the middle of an acknowledged handshake
    apply_reset();
    do_req(1, 8'd1, 4'h1);
    check("c1_take_s1", data, 32'h0000_1200);
    @(negedge clk);
    addr[7:0] = 8'd3;
    cmd[3:0]  = 4'h1;
    req[0]    = 1'b1;
    @(negedge clk);
    check("mid_ack", 32'(ack), 32'd1);
    check("mid_data", data, 32'h2100_1200);
    rst = 1'b1;
    #1;
    check("async_rst_ack", 32'(ack), 32'd0);
    check("async_rst_data", data, 32'h0000_0000);
    req = '0;
    @(negedge clk);
    rst = 1'b0;
    do_req(0, 8'd1, 4'h1);
    check("post_rst_take", data, 32'h0000_2100);
    do_req(1, 8'd3, 4'h2);
    check("give_free_denied", data, 32'h4000_2100);
    do_req(0, 8'd1, 4'h1);
    check("take_idempotent", data, 32'h4000_2100);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
